// File: rtl/alu_issue_ctrl_pkg.sv
// Shared definitions for the ALU issue/retire front end: ISA opcodes,
// ALU operation codes, exception codes, instruction field positions and
// the decoded instruction kind.
package alu_issue_ctrl_pkg;

    // Major opcodes, insn[31:27]
    localparam logic [4:0] ISA_RTYPE = 5'b00000;
    localparam logic [4:0] ISA_ADDI  = 5'b00101;
    localparam logic [4:0] ISA_BNE   = 5'b00010;
    localparam logic [4:0] ISA_BLT   = 5'b00110;

    // ALU operation codes
    localparam logic [4:0] ALU_ADD = 5'd0;
    localparam logic [4:0] ALU_SUB = 5'd1;
    localparam logic [4:0] ALU_AND = 5'd2;
    localparam logic [4:0] ALU_OR  = 5'd3;
    localparam logic [4:0] ALU_SLL = 5'd4;
    localparam logic [4:0] ALU_SRA = 5'd5;

    // Exception codes reported on out_exc
    localparam logic [1:0] EXC_NONE = 2'd0;
    localparam logic [1:0] EXC_OVF  = 2'd1;
    localparam logic [1:0] EXC_ILL  = 2'd2;

    // Instruction field bit positions
    localparam int OPC_HI   = 31;
    localparam int OPC_LO   = 27;
    localparam int RD_HI    = 26;
    localparam int RD_LO    = 22;
    localparam int RS_HI    = 21;
    localparam int RS_LO    = 17;
    localparam int SHAMT_HI = 11;
    localparam int SHAMT_LO = 7;
    localparam int FN_HI    = 6;
    localparam int FN_LO    = 2;
    localparam int IMM_HI   = 16;

    // Decoded instruction class; ARITH is the only class that reports overflow
    typedef enum logic [1:0] {
        KIND_LOGIC = 2'd0,
        KIND_ARITH = 2'd1,
        KIND_BNE   = 2'd2,
        KIND_BLT   = 2'd3
    } insn_kind_e;

    // Sign-extend the 17-bit immediate to 32 bits
    function automatic logic [31:0] sext_imm(input logic [16:0] imm);
        return {{15{imm[16]}}, imm};
    endfunction

endpackage

// File: rtl/alu_issue_alu.sv
// 32-bit integer ALU (combinational).
// Ports:
//   op            - ALU operation code (add, sub, and, or, sll, sra)
//   shamt         - shift amount applied to a
//   a, b          - operands
//   result        - operation result
//   is_not_equal  - a != b
//   is_less_than  - signed a < b
//   overflow      - signed overflow of add/sub
module alu_issue_alu
    import alu_issue_ctrl_pkg::*;
(
    input  logic [4:0]  op,
    input  logic [4:0]  shamt,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] result,
    output logic        is_not_equal,
    output logic        is_less_than,
    output logic        overflow
);

    logic [31:0] sum_s;
    logic [31:0] diff_s;

    assign sum_s        = a + b;
    assign diff_s       = a - b;
    assign is_not_equal = (a != b);
    assign is_less_than = ($signed(a) < $signed(b));

    // Operation select and signed overflow detection.
    always_comb begin
        result   = 32'd0;
        overflow = 1'b0;
        case (op)
            ALU_ADD: begin
                result   = sum_s;
                overflow = (a[31] == b[31]) && (sum_s[31] != a[31]);
            end
            ALU_SUB: begin
                result   = diff_s;
                overflow = (a[31] != b[31]) && (diff_s[31] != a[31]);
            end
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_SLL: result = a << shamt;
            ALU_SRA: result = 32'($signed(a) >>> shamt);
            default: result = 32'd0;
        endcase
    end

endmodule

// File: rtl/alu_issue_decode.sv
// Purely combinational instruction decode.
// Ports:
//   insn     - instruction word
//   rs_val   - rs operand value (rd-slot value for branches)
//   rt_val   - rt operand value
//   alu_op   - ALU operation code
//   shamt    - shift amount
//   rd       - destination register (0 for branches and illegal)
//   op_a     - ALU operand A
//   op_b     - ALU operand B
//   kind     - decoded instruction class
//   illegal  - instruction is not executable
module alu_issue_decode
    import alu_issue_ctrl_pkg::*;
(
    input  logic [31:0] insn,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic [4:0]  alu_op,
    output logic [4:0]  shamt,
    output logic [4:0]  rd,
    output logic [31:0] op_a,
    output logic [31:0] op_b,
    output insn_kind_e  kind,
    output logic        illegal
);

    logic [4:0] opcode_s;
    logic [4:0] fn_s;
    logic       unused_rs_field_s;

    assign opcode_s = insn[OPC_HI:OPC_LO];
    assign fn_s     = insn[FN_HI:FN_LO];
    // Operand values arrive pre-read, so the rs register index is not needed here.
    assign unused_rs_field_s = ^insn[RS_HI:RS_LO];

    // Field decode; illegal instructions leave operands at zero so nothing leaks.
    always_comb begin
        alu_op  = ALU_ADD;
        shamt   = 5'd0;
        rd      = 5'd0;
        op_a    = 32'd0;
        op_b    = 32'd0;
        kind    = KIND_LOGIC;
        illegal = 1'b0;
        case (opcode_s)
            ISA_RTYPE: begin
                if (fn_s <= ALU_SRA) begin
                    alu_op = fn_s;
                    shamt  = insn[SHAMT_HI:SHAMT_LO];
                    rd     = insn[RD_HI:RD_LO];
                    op_a   = rs_val;
                    op_b   = rt_val;
                    kind   = ((fn_s == ALU_ADD) || (fn_s == ALU_SUB)) ? KIND_ARITH : KIND_LOGIC;
                end else begin
                    illegal = 1'b1;
                end
            end
            ISA_ADDI: begin
                alu_op = ALU_ADD;
                rd     = insn[RD_HI:RD_LO];
                op_a   = rs_val;
                op_b   = sext_imm(insn[IMM_HI:0]);
                kind   = KIND_ARITH;
            end
            ISA_BNE: begin
                alu_op = ALU_SUB;
                op_a   = rs_val;
                op_b   = rt_val;
                kind   = KIND_BNE;
            end
            ISA_BLT: begin
                alu_op = ALU_SUB;
                op_a   = rs_val;
                op_b   = rt_val;
                kind   = KIND_BLT;
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Two-stage issue/retire front end for the 32-bit ALU.
// S1 holds decoded controls and operands; S2 holds the registered result.
// Ports:
//   clock, reset_n            - clock, asynchronous active-low reset
//   in_valid/in_ready         - request handshake (in_insn, in_rs_val, in_rt_val)
//   out_valid/out_ready       - response handshake
//   out_rd, out_result        - destination register and ALU result
//   out_taken                 - branch condition
//   out_exc                   - 0 none, 1 overflow, 2 illegal
//   retired_cnt               - saturating count of consumed responses
module alu_issue_ctrl
    import alu_issue_ctrl_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_insn,
    input  logic [31:0]      in_rs_val,
    input  logic [31:0]      in_rt_val,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [4:0]       out_rd,
    output logic [31:0]      out_result,
    output logic             out_taken,
    output logic [1:0]       out_exc,
    output logic [CNT_W-1:0] retired_cnt
);

    // Decode outputs
    logic [4:0]  dec_alu_op_s;
    logic [4:0]  dec_shamt_s;
    logic [4:0]  dec_rd_s;
    logic [31:0] dec_a_s;
    logic [31:0] dec_b_s;
    insn_kind_e  dec_kind_s;
    logic        dec_illegal_s;

    // Stage 1
    logic        s1_valid_r;
    logic [4:0]  s1_alu_op_r;
    logic [4:0]  s1_shamt_r;
    logic [4:0]  s1_rd_r;
    logic [31:0] s1_a_r;
    logic [31:0] s1_b_r;
    insn_kind_e  s1_kind_r;
    logic        s1_illegal_r;

    // ALU outputs
    logic [31:0] alu_result_s;
    logic        alu_ne_s;
    logic        alu_lt_s;
    logic        alu_ovf_s;

    // Stage 2 next values and registers
    logic [4:0]  s2_rd_nx_s;
    logic [31:0] s2_result_nx_s;
    logic        s2_taken_nx_s;
    logic [1:0]  s2_exc_nx_s;
    logic        s2_valid_r;
    logic [4:0]  s2_rd_r;
    logic [31:0] s2_result_r;
    logic        s2_taken_r;
    logic [1:0]  s2_exc_r;

    logic [CNT_W-1:0] retired_cnt_r;
    logic             s2_adv_s;
    logic             s1_adv_s;

    // A stage may load when it is empty or its content leaves this cycle.
    assign s2_adv_s = !s2_valid_r || out_ready;
    assign s1_adv_s = !s1_valid_r || s2_adv_s;
    assign in_ready = s1_adv_s;

    assign out_valid   = s2_valid_r;
    assign out_rd      = s2_rd_r;
    assign out_result  = s2_result_r;
    assign out_taken   = s2_taken_r;
    assign out_exc     = s2_exc_r;
    assign retired_cnt = retired_cnt_r;

    alu_issue_decode u_decode (
        .insn    (in_insn),
        .rs_val  (in_rs_val),
        .rt_val  (in_rt_val),
        .alu_op  (dec_alu_op_s),
        .shamt   (dec_shamt_s),
        .rd      (dec_rd_s),
        .op_a    (dec_a_s),
        .op_b    (dec_b_s),
        .kind    (dec_kind_s),
        .illegal (dec_illegal_s)
    );

    alu_issue_alu u_alu (
        .op           (s1_alu_op_r),
        .shamt        (s1_shamt_r),
        .a            (s1_a_r),
        .b            (s1_b_r),
        .result       (alu_result_s),
        .is_not_equal (alu_ne_s),
        .is_less_than (alu_lt_s),
        .overflow     (alu_ovf_s)
    );

    // Stage 1 register: decoded controls and operands.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_r   <= 1'b0;
            s1_alu_op_r  <= ALU_ADD;
            s1_shamt_r   <= 5'd0;
            s1_rd_r      <= 5'd0;
            s1_a_r       <= 32'd0;
            s1_b_r       <= 32'd0;
            s1_kind_r    <= KIND_LOGIC;
            s1_illegal_r <= 1'b0;
        end else if (s1_adv_s) begin
            s1_valid_r   <= in_valid;
            s1_alu_op_r  <= dec_alu_op_s;
            s1_shamt_r   <= dec_shamt_s;
            s1_rd_r      <= dec_rd_s;
            s1_a_r       <= dec_a_s;
            s1_b_r       <= dec_b_s;
            s1_kind_r    <= dec_kind_s;
            s1_illegal_r <= dec_illegal_s;
        end
    end

    // Response formation: illegal masks every ALU output; only add/sub/addi report overflow.
    always_comb begin
        s2_rd_nx_s     = s1_rd_r;
        s2_result_nx_s = alu_result_s;
        s2_taken_nx_s  = 1'b0;
        s2_exc_nx_s    = EXC_NONE;
        if (s1_illegal_r) begin
            s2_rd_nx_s     = 5'd0;
            s2_result_nx_s = 32'd0;
            s2_exc_nx_s    = EXC_ILL;
        end else begin
            case (s1_kind_r)
                KIND_ARITH: s2_exc_nx_s   = alu_ovf_s ? EXC_OVF : EXC_NONE;
                KIND_BNE:   s2_taken_nx_s = alu_ne_s;
                KIND_BLT:   s2_taken_nx_s = alu_lt_s;
                KIND_LOGIC: s2_taken_nx_s = 1'b0;
                default:    s2_taken_nx_s = 1'b0;
            endcase
        end
    end

    // Stage 2 register: response held stable while the consumer stalls.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s2_valid_r  <= 1'b0;
            s2_rd_r     <= 5'd0;
            s2_result_r <= 32'd0;
            s2_taken_r  <= 1'b0;
            s2_exc_r    <= EXC_NONE;
        end else if (s2_adv_s) begin
            s2_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                s2_rd_r     <= s2_rd_nx_s;
                s2_result_r <= s2_result_nx_s;
                s2_taken_r  <= s2_taken_nx_s;
                s2_exc_r    <= s2_exc_nx_s;
            end
        end
    end

    // Saturating count of consumed responses.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            retired_cnt_r <= {CNT_W{1'b0}};
        end else if (s2_valid_r && out_ready && (retired_cnt_r != {CNT_W{1'b1}})) begin
            retired_cnt_r <= retired_cnt_r + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: directed vector table plus
// hand-written backpressure, mid-operation reset and counter saturation sequences.
module tb_alu_issue_ctrl;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_insn = 32'd0;
    logic [31:0] in_rs_val = 32'd0;
    logic [31:0] in_rt_val = 32'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [4:0]  out_rd;
    logic [31:0] out_result;
    logic        out_taken;
    logic [1:0]  out_exc;
    logic [15:0] retired_cnt;

    // Second instance with a 2-bit counter for the saturation check
    logic        c2_in_valid = 1'b0;
    logic        c2_in_ready;
    logic [31:0] c2_in_insn = 32'd0;
    logic [31:0] c2_in_rs_val = 32'd0;
    logic [31:0] c2_in_rt_val = 32'd0;
    logic        c2_out_valid;
    logic        c2_out_ready = 1'b0;
    logic [4:0]  c2_out_rd;
    logic [31:0] c2_out_result;
    logic        c2_out_taken;
    logic [1:0]  c2_out_exc;
    logic [1:0]  c2_retired_cnt;

    int checks = 0;
    int errors = 0;

    alu_issue_ctrl #(.CNT_W(16)) dut (
        .clock(clock), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_insn(in_insn),
        .in_rs_val(in_rs_val), .in_rt_val(in_rt_val),
        .out_valid(out_valid), .out_ready(out_ready), .out_rd(out_rd),
        .out_result(out_result), .out_taken(out_taken), .out_exc(out_exc),
        .retired_cnt(retired_cnt)
    );

    alu_issue_ctrl #(.CNT_W(2)) dut_c2 (
        .clock(clock), .reset_n(reset_n),
        .in_valid(c2_in_valid), .in_ready(c2_in_ready), .in_insn(c2_in_insn),
        .in_rs_val(c2_in_rs_val), .in_rt_val(c2_in_rt_val),
        .out_valid(c2_out_valid), .out_ready(c2_out_ready), .out_rd(c2_out_rd),
        .out_result(c2_out_result), .out_taken(c2_out_taken), .out_exc(c2_out_exc),
        .retired_cnt(c2_retired_cnt)
    );

    always #5 clock = ~clock;

    typedef struct {
        string       name;
        logic [31:0] insn;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [4:0]  rd;
        logic [31:0] result;
        logic        taken;
        logic [1:0]  exc;
    } vec_t;

    vec_t vecs[15];

    function automatic logic [31:0] mk_r(input logic [4:0] fn, input logic [4:0] rd, input logic [4:0] sh);
        return {5'b00000, rd, 5'd1, 5'd2, sh, fn, 2'b00};
    endfunction

    function automatic logic [31:0] mk_i(input logic [4:0] op, input logic [4:0] rd, input logic [16:0] imm);
        return {op, rd, 5'd1, imm};
    endfunction

    function automatic vec_t mkv(input string n, input logic [31:0] insn, input logic [31:0] rs,
                                 input logic [31:0] rt, input logic [4:0] rd, input logic [31:0] res,
                                 input logic tk, input logic [1:0] exc);
        vec_t v;
        v.name = n; v.insn = insn; v.rs = rs; v.rt = rt;
        v.rd = rd; v.result = res; v.taken = tk; v.exc = exc;
        return v;
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        c2_in_valid = 1'b0;
        c2_out_ready = 1'b0;
        @(posedge clock);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        vecs[0]  = mkv("add_ovf",  mk_r(5'd0, 5'd3, 5'd0), 32'h7FFFFFFF, 32'h00000001, 5'd3, 32'h80000000, 1'b0, 2'd1);
        vecs[1]  = mkv("addi_neg", mk_i(5'b00101, 5'd5, 17'h1FFFF), 32'd10, 32'h0000DEAD, 5'd5, 32'd9, 1'b0, 2'd0);
        vecs[2]  = mkv("sra4",     mk_r(5'd5, 5'd7, 5'd4), 32'h80000000, 32'h12345678, 5'd7, 32'hF8000000, 1'b0, 2'd0);
        vecs[3]  = mkv("blt_tk",   mk_i(5'b00110, 5'd9, 17'd0), 32'hFFFFFFFE, 32'h00000001, 5'd0, 32'hFFFFFFFD, 1'b1, 2'd0);
        vecs[4]  = mkv("bne_eq",   mk_i(5'b00010, 5'd9, 17'd0), 32'd7, 32'd7, 5'd0, 32'd0, 1'b0, 2'd0);
        vecs[5]  = mkv("ill_op",   mk_i(5'b11111, 5'd4, 17'h00100), 32'd5, 32'd3, 5'd0, 32'd0, 1'b0, 2'd2);
        vecs[6]  = mkv("ill_fn6",  mk_r(5'd6, 5'd3, 5'd0), 32'h7FFFFFFF, 32'h00000001, 5'd0, 32'd0, 1'b0, 2'd2);
        vecs[7]  = mkv("sub_ovf",  mk_r(5'd1, 5'd4, 5'd0), 32'h80000000, 32'h00000001, 5'd4, 32'h7FFFFFFF, 1'b0, 2'd1);
        vecs[8]  = mkv("and",      mk_r(5'd2, 5'd1, 5'd0), 32'hF0F0F0F0, 32'h0FF00FF0, 5'd1, 32'h00F000F0, 1'b0, 2'd0);
        vecs[9]  = mkv("or",       mk_r(5'd3, 5'd2, 5'd0), 32'h12340000, 32'h00005678, 5'd2, 32'h12345678, 1'b0, 2'd0);
        vecs[10] = mkv("sll8",     mk_r(5'd4, 5'd6, 5'd8), 32'h000000AB, 32'h00000000, 5'd6, 32'h0000AB00, 1'b0, 2'd0);
        vecs[11] = mkv("bne_ne",   mk_i(5'b00010, 5'd9, 17'd0), 32'd7, 32'd8, 5'd0, 32'hFFFFFFFF, 1'b1, 2'd0);
        vecs[12] = mkv("blt_noov", mk_i(5'b00110, 5'd9, 17'd0), 32'h80000000, 32'h00000001, 5'd0, 32'h7FFFFFFF, 1'b1, 2'd0);
        vecs[13] = mkv("blt_nt",   mk_i(5'b00110, 5'd9, 17'd0), 32'd5, 32'd1, 5'd0, 32'd4, 1'b0, 2'd0);
        vecs[14] = mkv("add_rd0",  mk_r(5'd0, 5'd0, 5'd0), 32'd2, 32'd3, 5'd0, 32'd5, 1'b0, 2'd0);

        // Reset state
        #2;
        check32("rst_in_ready", in_ready, 1);
        check32("rst_out_valid", out_valid, 0);
        check32("rst_out_rd", out_rd, 0);
        check32("rst_out_result", out_result, 0);
        check32("rst_out_taken", out_taken, 0);
        check32("rst_out_exc", out_exc, 0);
        check32("rst_retired", retired_cnt, 0);
        check32("rst_c2_retired", c2_retired_cnt, 0);
        apply_reset();

        // Directed vectors: one request at a time, two-edge latency
        for (int i = 0; i < 15; i++) begin
            out_ready = 1'b1;
            in_insn = vecs[i].insn;
            in_rs_val = vecs[i].rs;
            in_rt_val = vecs[i].rt;
            in_valid = 1'b1;
            check32({vecs[i].name, "_in_ready"}, in_ready, 1);
            step();
            in_valid = 1'b0;
            check32({vecs[i].name, "_early"}, out_valid, 0);
            step();
            check32({vecs[i].name, "_valid"}, out_valid, 1);
            check32({vecs[i].name, "_rd"}, out_rd, vecs[i].rd);
            check32({vecs[i].name, "_result"}, out_result, vecs[i].result);
            check32({vecs[i].name, "_taken"}, out_taken, vecs[i].taken);
            check32({vecs[i].name, "_exc"}, out_exc, vecs[i].exc);
            step();
        end
        check32("table_retired", retired_cnt, 15);

        // Backpressure: 4 back-to-back adds, consumer stalls 3 cycles on first response
        begin
            int sent = 0;
            int recv = 0;
            int hold_left = 0;
            bit hold_started = 1'b0;
            bit saw_ready_low = 1'b0;
            bit in_hs;
            apply_reset();
            for (int cyc = 0; cyc < 40 && recv < 4; cyc++) begin
                if (out_valid && !hold_started) begin
                    hold_started = 1'b1;
                    hold_left = 3;
                end
                out_ready = (hold_left == 0);
                if (hold_left > 0) hold_left--;
                in_valid = (sent < 4);
                in_insn = mk_r(5'd0, 5'(sent + 1), 5'd0);
                in_rs_val = 32'(100 * sent);
                in_rt_val = 32'(sent + 1);
                #1;
                if (out_valid && !out_ready) begin
                    check32("bp_hold_result", out_result, 32'(101 * recv + 1));
                    check32("bp_hold_rd", out_rd, 32'(recv + 1));
                    if (!in_ready) saw_ready_low = 1'b1;
                end
                if (out_valid && out_ready) begin
                    check32("bp_resp_result", out_result, 32'(101 * recv + 1));
                    check32("bp_resp_rd", out_rd, 32'(recv + 1));
                    check32("bp_resp_exc", out_exc, 0);
                    recv++;
                end
                in_hs = in_valid && in_ready;
                step();
                if (in_hs) sent++;
            end
            in_valid = 1'b0;
            check32("bp_responses", recv, 4);
            check32("bp_in_ready_low", saw_ready_low, 1);
            check32("bp_retired", retired_cnt, 4);
        end

        // Reset with both stages full
        out_ready = 1'b0;
        in_insn = mk_r(5'd0, 5'd8, 5'd0);
        in_rs_val = 32'd1;
        in_rt_val = 32'd1;
        in_valid = 1'b1;
        step();
        step();
        in_valid = 1'b0;
        check32("full_out_valid", out_valid, 1);
        check32("full_in_ready", in_ready, 0);
        #2;
        reset_n = 1'b0;
        #1;
        check32("midrst_out_valid", out_valid, 0);
        check32("midrst_retired", retired_cnt, 0);
        check32("midrst_in_ready", in_ready, 1);
        step();
        reset_n = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check32("postrst_out_valid", out_valid, 0);
        end
        check32("postrst_retired", retired_cnt, 0);

        // Counter saturation on the 2-bit instance
        begin
            int c2_sent = 0;
            int hs = 0;
            bit in_hs;
            c2_out_ready = 1'b1;
            for (int cyc = 0; cyc < 30 && hs < 5; cyc++) begin
                c2_in_valid = (c2_sent < 5);
                c2_in_insn = mk_r(5'd0, 5'd1, 5'd0);
                c2_in_rs_val = 32'(cyc);
                c2_in_rt_val = 32'd0;
                #1;
                if (c2_out_valid && c2_out_ready) hs++;
                in_hs = c2_in_valid && c2_in_ready;
                step();
                if (in_hs) c2_sent++;
            end
            c2_in_valid = 1'b0;
            check32("sat_handshakes", hs, 5);
            check32("sat_retired", c2_retired_cnt, 3);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
